vga_timing_cfg: RTL
===================

VGA_TIMING_CFG -- requirements
Module: vga_timing_cfg

Interface
REQ-001 SHALL have parameter CFG_W, default 8, width of the config address and data buses.
REQ-002 SHALL have parameter VGA_ADDR, default 2, config address decoded by this block.
REQ-003 SHALL have parameter NUM_MODES, default 4, range 1..4, number of legal modes.
REQ-004 SHALL have parameter DEFAULT_MODE, default 0, mode loaded at reset; must be less than NUM_MODES.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1048576, cycles in PEND before a forced apply; 0 disables forced apply.
REQ-006 SHALL have port Clk, input, 1 bit, clock.
REQ-007 SHALL have port Rst, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port C_valid, input, 1 bit, config request valid.
REQ-009 SHALL have port C_addr, input, CFG_W bits, config address.
REQ-010 SHALL have port C_data, input, CFG_W bits, requested mode index.
REQ-011 SHALL have port C_rdy, output, 1 bit, block can accept a request.
REQ-012 SHALL have port Frame_end, input, 1 bit, one-cycle pulse from the counters at the last pixel of a frame.
REQ-013 SHALL have port Err, output, 1 bit, one-cycle pulse on an illegal mode request.
REQ-014 SHALL have port Busy, output, 1 bit, high when state is not IDLE.
REQ-015 SHALL have port Load_config, output, 1 bit, one-cycle pulse when new parameters become valid.
REQ-016 SHALL have port Cur_mode, output, 2 bits, currently applied mode.
REQ-017 SHALL have ports H_count_max and V_count_max, output, 11 bits each, total pixels/lines minus 1.
REQ-018 SHALL have ports H_sync_pulse and V_sync_pulse, output, 8 bits each, sync width.
REQ-019 SHALL have ports H_left_margin and V_left_margin, output, 8 bits each, back porch.
REQ-020 SHALL have ports H_right_margin and V_right_margin, output, 8 bits each, front porch.

Function
REQ-021 SHALL use this mode table, listed as Htot/Vtot/Hsync/Vsync/Hfp/Hbp/Vfp/Vbp:
- mode 0: 800/525/96/2/16/48/10/33
- mode 1: 1056/628/128/4/40/88/1/23
- mode 2: 1344/806/136/6/24/160/3/29
- mode 3: 1688/1066/112/3/48/248/1/38
REQ-022 SHALL implement an FSM with states IDLE, PEND and LOAD; C_rdy shall be 1 only in IDLE.
REQ-023 SHALL treat a request as accepted when C_valid=1, C_rdy=1 and C_addr==VGA_ADDR; a request with any other address is ignored and causes no state change.
REQ-024 SHALL, on an accepted request with C_data>=NUM_MODES, pulse Err on the next cycle, stay in IDLE and leave all outputs unchanged.
REQ-025 SHALL, on an accepted request with C_data==Cur_mode, treat it as a no-op: stay in IDLE, no Load_config, no Err.
REQ-026 SHALL, on any other accepted request, latch the mode into a pending register and move IDLE->PEND.
REQ-027 SHALL, in PEND, on Frame_end=1 or when the timeout counter reaches TIMEOUT_CYC-1, update all parameter outputs and Cur_mode from the pending mode on that edge and move to LOAD.
REQ-028 SHALL ignore a Frame_end pulse that coincides with the accepting cycle; apply waits for the next Frame_end.
REQ-029 SHALL clear the timeout counter on entry to PEND; the counter increments each cycle in PEND and saturates.
REQ-030 SHALL assert Load_config=1 for exactly the one LOAD cycle, then move LOAD->IDLE.
REQ-031 SHALL ignore Frame_end while in IDLE or LOAD.
REQ-032 SHALL change parameter outputs only on the PEND->LOAD edge, giving glitch-free per-frame switching.

Reset
REQ-033 SHALL, while Rst=0, drive: state IDLE, parameter outputs and Cur_mode from DEFAULT_MODE, Load_config=1, Err=0, Busy=0, C_rdy=0, pending and timeout registers cleared.
REQ-034 SHALL, on the first Clk edge after Rst deasserts, drive Load_config=0 and C_rdy=1.
REQ-035 SHALL, on reset during PEND or LOAD, discard the pending mode; outputs revert to DEFAULT_MODE.

Structure
REQ-036 SHALL place the mode encodings, the timing table constants and the output widths in the shared VGA package.
REQ-037 SHALL implement the mode-to-parameter lookup in a purely combinational sub-module named vga_mode_rom.

Verification
REQ-038 SHALL cover reset: release Rst -> Load_config=1 for one cycle, H_count_max=799, V_count_max=524, Cur_mode=0.
REQ-039 SHALL cover a mode change: request addr 2 data 1, then Frame_end 10 cycles later -> Busy for 11 cycles, Load_config pulse, H_count_max=1055, V_sync_pulse=4, C_rdy=1 afterwards.
REQ-040 SHALL cover an illegal mode: NUM_MODES=3, request data 3 -> Err pulse, no Load_config, outputs unchanged.
REQ-041 SHALL cover a coincident Frame_end: request data 2 in the same cycle as Frame_end -> no apply until the next Frame_end, then H_left_margin=160.
REQ-042 SHALL cover the timeout: TIMEOUT_CYC=16, request data 3, no Frame_end -> apply on the 16th PEND cycle, V_count_max=1065.
REQ-043 SHALL cover requests that must be ignored: wrong address (addr 1) and same-mode request -> no Busy, no Load_config, no Err.

Source files
------------

// File: rtl/vga_timing_cfg_pkg.sv
// Shared definitions for the VGA timing configuration block: mode encodings,
// the per-mode timing table and the widths of the timing parameter outputs.
package vga_timing_cfg_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned CNT_MAX_W = 11;
    localparam int unsigned TIMING_W  = 8;
    localparam int unsigned MAX_MODES = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_640X480   = 2'd0,
        MODE_800X600   = 2'd1,
        MODE_1024X768  = 2'd2,
        MODE_1280X1024 = 2'd3
    } vga_mode_e;

    // Raw table entry in the natural units: totals, sync widths and porches.
    typedef struct packed {
        logic [CNT_MAX_W-1:0] h_total;
        logic [CNT_MAX_W-1:0] v_total;
        logic [TIMING_W-1:0]  h_sync;
        logic [TIMING_W-1:0]  v_sync;
        logic [TIMING_W-1:0]  h_fp;
        logic [TIMING_W-1:0]  h_bp;
        logic [TIMING_W-1:0]  v_fp;
        logic [TIMING_W-1:0]  v_bp;
    } vga_timing_t;

    // Values as presented to the pixel/line counters.
    typedef struct packed {
        logic [CNT_MAX_W-1:0] h_count_max;
        logic [CNT_MAX_W-1:0] v_count_max;
        logic [TIMING_W-1:0]  h_sync_pulse;
        logic [TIMING_W-1:0]  v_sync_pulse;
        logic [TIMING_W-1:0]  h_left_margin;
        logic [TIMING_W-1:0]  h_right_margin;
        logic [TIMING_W-1:0]  v_left_margin;
        logic [TIMING_W-1:0]  v_right_margin;
    } vga_params_t;

    // Htot / Vtot / Hsync / Vsync / Hfp / Hbp / Vfp / Vbp
    localparam vga_timing_t MODE_TABLE [MAX_MODES] = '{
        '{11'd800,  11'd525,  8'd96,  8'd2, 8'd16, 8'd48,  8'd10, 8'd33},
        '{11'd1056, 11'd628,  8'd128, 8'd4, 8'd40, 8'd88,  8'd1,  8'd23},
        '{11'd1344, 11'd806,  8'd136, 8'd6, 8'd24, 8'd160, 8'd3,  8'd29},
        '{11'd1688, 11'd1066, 8'd112, 8'd3, 8'd48, 8'd248, 8'd1,  8'd38}
    };

    // Counters run 0..total-1; left margin is the back porch, right the front porch.
    function automatic vga_params_t timing_to_params(input vga_timing_t t);
        vga_params_t p;
        p.h_count_max    = t.h_total - 11'd1;
        p.v_count_max    = t.v_total - 11'd1;
        p.h_sync_pulse   = t.h_sync;
        p.v_sync_pulse   = t.v_sync;
        p.h_left_margin  = t.h_bp;
        p.h_right_margin = t.h_fp;
        p.v_left_margin  = t.v_bp;
        p.v_right_margin = t.v_fp;
        return p;
    endfunction

endpackage

// File: rtl/vga_mode_rom.sv
// Combinational mode-to-timing lookup for the VGA timing configuration block.
module vga_mode_rom
    import vga_timing_cfg_pkg::*;
(
    input  logic [MODE_W-1:0]    mode_i,
    output logic [CNT_MAX_W-1:0] h_count_max_o,
    output logic [CNT_MAX_W-1:0] v_count_max_o,
    output logic [TIMING_W-1:0]  h_sync_pulse_o,
    output logic [TIMING_W-1:0]  v_sync_pulse_o,
    output logic [TIMING_W-1:0]  h_left_margin_o,
    output logic [TIMING_W-1:0]  h_right_margin_o,
    output logic [TIMING_W-1:0]  v_left_margin_o,
    output logic [TIMING_W-1:0]  v_right_margin_o
);

    vga_params_t params;

    // Select the table entry for the requested mode and convert to counter form.
    always_comb begin
        params = timing_to_params(MODE_TABLE[mode_i]);
    end

    assign h_count_max_o    = params.h_count_max;
    assign v_count_max_o    = params.v_count_max;
    assign h_sync_pulse_o   = params.h_sync_pulse;
    assign v_sync_pulse_o   = params.v_sync_pulse;
    assign h_left_margin_o  = params.h_left_margin;
    assign h_right_margin_o = params.h_right_margin;
    assign v_left_margin_o  = params.v_left_margin;
    assign v_right_margin_o = params.v_right_margin;

endmodule

// File: rtl/vga_timing_cfg.sv
// VGA timing configuration: accepts mode-change requests on the config bus,
// holds them pending until the end of the current frame (or a timeout) and
// then switches all timing parameters together in a single clock edge.
module vga_timing_cfg
    import vga_timing_cfg_pkg::*;
#(
    parameter int unsigned CFG_W        = 8,
    parameter int unsigned VGA_ADDR     = 2,
    parameter int unsigned NUM_MODES    = 4,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned TIMEOUT_CYC  = 1048576
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 C_valid,
    input  logic [CFG_W-1:0]     C_addr,
    input  logic [CFG_W-1:0]     C_data,
    output logic                 C_rdy,
    input  logic                 Frame_end,
    output logic                 Err,
    output logic                 Busy,
    output logic                 Load_config,
    output logic [MODE_W-1:0]    Cur_mode,
    output logic [CNT_MAX_W-1:0] H_count_max,
    output logic [CNT_MAX_W-1:0] V_count_max,
    output logic [TIMING_W-1:0]  H_sync_pulse,
    output logic [TIMING_W-1:0]  V_sync_pulse,
    output logic [TIMING_W-1:0]  H_left_margin,
    output logic [TIMING_W-1:0]  V_left_margin,
    output logic [TIMING_W-1:0]  H_right_margin,
    output logic [TIMING_W-1:0]  V_right_margin
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_LOAD = 2'd2
    } state_e;

    localparam int unsigned      CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam vga_mode_e        RST_MODE   = vga_mode_e'(MODE_W'(DEFAULT_MODE));
    localparam vga_params_t      RST_PARAMS = timing_to_params(MODE_TABLE[DEFAULT_MODE]);

    state_e           state_q, state_d;
    vga_mode_e        pend_q, pend_d;
    vga_mode_e        cur_mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             init_q;
    vga_params_t      params_q;
    vga_params_t      rom_params;
    logic             apply;
    logic             accept;
    logic             timeout_hit;

    vga_mode_rom u_rom (
        .mode_i           (pend_q),
        .h_count_max_o    (rom_params.h_count_max),
        .v_count_max_o    (rom_params.v_count_max),
        .h_sync_pulse_o   (rom_params.h_sync_pulse),
        .v_sync_pulse_o   (rom_params.v_sync_pulse),
        .h_left_margin_o  (rom_params.h_left_margin),
        .h_right_margin_o (rom_params.h_right_margin),
        .v_left_margin_o  (rom_params.v_left_margin),
        .v_right_margin_o (rom_params.v_right_margin)
    );

    // init_q gates C_rdy and holds Load_config high until the first edge out of reset.
    assign C_rdy       = init_q && (state_q == ST_IDLE);
    assign Busy        = (state_q != ST_IDLE);
    assign Load_config = !init_q || (state_q == ST_LOAD);
    assign Err         = err_q;
    assign Cur_mode    = cur_mode_q;

    assign accept      = C_valid && C_rdy && (C_addr == CFG_W'(VGA_ADDR));
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

    // Next-state logic: decode requests in IDLE, wait for frame end or timeout in PEND.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        apply   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (C_data >= CFG_W'(NUM_MODES)) begin
                        err_d = 1'b1;
                    end else if (C_data != CFG_W'(cur_mode_q)) begin
                        pend_d  = vga_mode_e'(C_data[MODE_W-1:0]);
                        cnt_d   = '0;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (Frame_end || timeout_hit) begin
                    apply   = 1'b1;
                    state_d = ST_LOAD;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending request, timeout counter, error pulse and applied parameter set.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend_q     <= vga_mode_e'('0);
            cnt_q      <= '0;
            err_q      <= 1'b0;
            init_q     <= 1'b0;
            cur_mode_q <= RST_MODE;
            params_q   <= RST_PARAMS;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            init_q <= 1'b1;
            if (apply) begin
                cur_mode_q <= pend_q;
                params_q   <= rom_params;
            end
        end
    end

    assign H_count_max    = params_q.h_count_max;
    assign V_count_max    = params_q.v_count_max;
    assign H_sync_pulse   = params_q.h_sync_pulse;
    assign V_sync_pulse   = params_q.v_sync_pulse;
    assign H_left_margin  = params_q.h_left_margin;
    assign H_right_margin = params_q.h_right_margin;
    assign V_left_margin  = params_q.v_left_margin;
    assign V_right_margin = params_q.v_right_margin;

endmodule
